sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder_pkg.sv | 13 +
 rtl/sram_clear_fsm.sv | 60 ++++++
 rtl/sram_responder.sv | 90 +++++++++
 tb/tb_sram_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: data and byte-enable widths
// and the state encoding of the clear sequencer.
package sram_responder_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear sequencer for the SRAM responder: after reset release it walks
// every word index once, asking the memory to store the fill word, then
// parks in READY and raises init_done.
module sram_clear_fsm
    import sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_idx,
    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    clr_state_t            state_q;
    clr_state_t            state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    // State and index registers; any reset restarts the sweep at index 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep one word per cycle, leave CLEAR once the last index is written
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_we    = 1'b0;
        init_done = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = READY;
                end
            end
            READY: begin
                init_done = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clr_idx = cnt_q;

endmodule

// File: rtl/sram_responder.sv
// Single-port 32-bit SRAM responder for the fetch/load stages: one access
// per cycle, registered read-first data, byte write enables, a registered
// misalignment flag, and outputs that hold while no access is accepted.
// Optional feature macro: SRAM_ZERO_INIT_EN -- when defined, a clear
// sequencer fills the whole array with RESET_WORD after every reset and
// holds off requests until it finishes.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] RESET_WORD = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sram_en,
    input  logic [BE_WIDTH-1:0]   sram_we,
    input  logic [31:0]           sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_wdata,
    output logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  sram_err,
    output logic                  init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic                  misaligned;
    logic                  unused_addr_bits;

`ifdef SRAM_ZERO_INIT_EN
    sram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk       (clk),
        .resetn    (resetn),
        .clr_we    (clr_we),
        .clr_idx   (clr_idx),
        .init_done (init_done)
    );
`else
    logic ready_q;

    // Without a clear sweep the memory is usable from the first edge after reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign init_done = ready_q;
    assign clr_we    = 1'b0;
    assign clr_idx   = '0;
`endif

    assign accept           = sram_en && init_done;
    assign word_idx         = sram_addr[ADDR_WIDTH+1:2];
    assign misaligned       = |sram_addr[1:0];
    assign unused_addr_bits = ^sram_addr[31:ADDR_WIDTH+2];

    // Array writes: the clear sweep owns the port until init_done, then byte-lane writes
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= RESET_WORD;
        end else if (accept) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (sram_we[i]) begin
                    mem[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-first response register; holds its value on cycles without an accepted access
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_rdata <= '0;
            sram_err   <= 1'b0;
        end else if (accept) begin
            sram_rdata <= mem[word_idx];
            sram_err   <= misaligned;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder (ADDR_WIDTH=4, RESET_WORD=deadbeef).
// A driver issues accesses and pushes the expected response into a queue;
// a monitor pops one entry per pushed cycle and compares against the DUT.
// Works with SRAM_ZERO_INIT_EN defined or undefined.
module tb_sram_responder;

    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] RW    = 32'hdeadbeef;
`ifdef SRAM_ZERO_INIT_EN
    localparam bit ZERO_INIT = 1'b1;
`else
    localparam bit ZERO_INIT = 1'b0;
`endif
    localparam int INIT_LATENCY = ZERO_INIT ? DEPTH : 1;

    logic        clk;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_err;
    logic        init_done;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          rdata_known;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];
    logic [31:0] last_rdata;
    logic        last_err;
    bit          last_known;
    int          tests_run;
    int          tests_failed;
    int          cyc;

    sram_responder #(
        .ADDR_WIDTH (AW),
        .RESET_WORD (RW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_err   (sram_err),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Model state right after a reset release and completed init
    task automatic modelReset();
        last_rdata = 32'h0;
        last_err   = 1'b0;
        last_known = 1'b1;
        if (ZERO_INIT) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[i]   = RW;
                model_known[i] = 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the next edge
    task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input string tag);
        exp_t        e;
        int          idx;
        logic [31:0] mask;
        @(negedge clk);
        sram_en    = en;
        sram_we    = we;
        sram_addr  = addr;
        sram_wdata = wdata;
        e.tag = tag;
        if (en) begin
            idx           = int'((addr >> 2) % DEPTH);
            e.rdata       = model_mem[idx];
            e.rdata_known = model_known[idx];
            e.err         = (addr % 4) != 0;
            mask = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mask = mask | (32'hff << (8 * b));
            end
            model_mem[idx] = (model_mem[idx] & ~mask) | (wdata & mask);
            if (we == 4'hf) model_known[idx] = 1'b1;
            last_rdata = e.rdata;
            last_err   = e.err;
            last_known = e.rdata_known;
        end else begin
            e.rdata       = last_rdata;
            e.err         = last_err;
            e.rdata_known = last_known;
        end
        sb_q.push_back(e);
    endtask

    // Let the last queued access complete, then idle until the monitor has consumed everything
    task automatic drainQueue();
        int n;
        @(negedge clk);
        sram_en = 1'b0;
        sram_we = 4'h0;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drain", 32'(sb_q.size()), 32'h0);
    endtask

    // Count edges from reset release until init_done, optionally spraying requests meanwhile
    task automatic waitInit(input bit junk, output int cycles);
        cycles = 0;
        sram_en    = junk;
        sram_we    = 4'hf;
        sram_addr  = 32'h1c000000 + 4 * $urandom_range(0, DEPTH - 1);
        sram_wdata = $urandom;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (init_done === 1'b1) break;
            sram_addr  = 32'h1c000000 + 4 * $urandom_range(0, DEPTH - 1);
            sram_wdata = $urandom;
        end
        sram_en = 1'b0;
        sram_we = 4'h0;
    endtask

    // Monitor: one queued expectation per driven cycle, compared just after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                if (mon_e.rdata_known) begin
                    checkOutput($sformatf("%s rdata", mon_e.tag), sram_rdata, mon_e.rdata);
                end
                checkOutput($sformatf("%s err", mon_e.tag), {31'b0, sram_err}, {31'b0, mon_e.err});
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        sram_en      = 1'b0;
        sram_we      = 4'h0;
        sram_addr    = 32'h0;
        sram_wdata   = 32'h0;
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset rdata", sram_rdata, 32'h0);
        checkOutput("reset err", {31'b0, sram_err}, 32'h0);
        checkOutput("reset init_done", {31'b0, init_done}, 32'h0);

        resetn = 1'b1;
        waitInit(1'b0, cyc);
        checkOutput("init_done latency", 32'(cyc), 32'(INIT_LATENCY));
        modelReset();

        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 4'h0, 32'h1c000000 + 4 * i, 32'h0, $sformatf("post-init read w%0d", i));
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 4'hf, 32'h1c000000 + 4 * i, $urandom, $sformatf("fill write w%0d", i));

        applyStimulus(1'b1, 4'hf, 32'h1c000000, 32'h11223344, "byte write full");
        applyStimulus(1'b1, 4'h5, 32'h1c000000, 32'haabbccdd, "byte write partial");
        applyStimulus(1'b1, 4'h0, 32'h1c000000, 32'h0, "byte write readback");

        applyStimulus(1'b1, 4'h0, 32'h1c000004, 32'h0, "hold read");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 4'h0, 32'h1c000004, $urandom, $sformatf("hold idle %0d", i));

        applyStimulus(1'b1, 4'h0, 32'h1c000006, 32'h0, "misaligned read");
        applyStimulus(1'b1, 4'h0, 32'h1c000008, 32'h0, "aligned after misaligned");
        applyStimulus(1'b1, 4'hf, 32'h1bfffffc, 32'h0badf00d, "alias top write");
        applyStimulus(1'b1, 4'h0, 32'h0000003c, 32'h0, "alias top read");

        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 1) != 0) ? 4'(($urandom)) : 4'h0,
                          $urandom, $urandom, $sformatf("random %0d", i));

        applyStimulus(1'b1, 4'hf, 32'h1c000008, 32'hcafef00d, "pre-reset write");
        applyStimulus(1'b1, 4'h0, 32'h1c000008, 32'h0, "pre-reset read");
        drainQueue();

        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async reset rdata", sram_rdata, 32'h0);
        checkOutput("async reset err", {31'b0, sram_err}, 32'h0);
        checkOutput("async reset init_done", {31'b0, init_done}, 32'h0);

        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sram_en    = ZERO_INIT;
            sram_we    = 4'hf;
            sram_addr  = 32'h1c000000 + 4 * $urandom_range(0, DEPTH - 1);
            sram_wdata = $urandom;
            @(posedge clk);
            #1;
        end
        sram_en = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("mid-clear reset init_done", {31'b0, init_done}, 32'h0);
        checkOutput("mid-clear reset rdata", sram_rdata, 32'h0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sram_en    = 1'b1;
            sram_we    = 4'hf;
            sram_addr  = 32'h1c000000 + 4 * i;
            sram_wdata = 32'h5a5a5a5a;
        end
        @(negedge clk);
        sram_en = 1'b0;
        resetn  = 1'b1;
        waitInit(ZERO_INIT, cyc);
        checkOutput("restart init_done latency", 32'(cyc), 32'(INIT_LATENCY));
        modelReset();

        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 4'h0, 32'h1c000000 + 4 * i, 32'h0, $sformatf("post-restart read w%0d", i));
        drainQueue();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
